sfifo_stream_reader: RTL

Read-side adapter placed directly downstream of the synchronous FIFO. It converts the FIFO's request/empty read port, which has one-cycle read-data latency, into a valid/ready stream with full throughput. Words are prefetched into a 2-entry local buffer, so the FIFO's read latency is hidden from the consumer. An optional burst framer marks every BurstLen-th transferred word with OutLast.

---
 rtl/fifo_pkg.sv | 6 +
 rtl/sfifo_stream_reader_if.sv | 24 ++
 rtl/stream_buf2.sv | 50 +++++
 rtl/sfifo_stream_reader.sv | 60 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Constants shared by the FIFO read-side stream adapter and its buffer.
package fifo_pkg;
    localparam int RD_LATENCY    = 1;
    localparam int OUT_BUF_DEPTH = 2;
    localparam int CNT_W         = $clog2(OUT_BUF_DEPTH + 1);
endpackage

// File: rtl/sfifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream seen by sfifo_stream_reader.
interface sfifo_stream_reader_if #(
    parameter int Width    = 8,
    parameter int LenWidth = 8
);
    logic                FIFOEmpty;
    logic [Width-1:0]    RDData;
    logic                FIFORdReq;
    logic [LenWidth-1:0] BurstLen;
    logic [Width-1:0]    OutData;
    logic                OutValid;
    logic                OutReady;
    logic                OutLast;

    modport master (
        input  FIFOEmpty, RDData, BurstLen, OutReady,
        output FIFORdReq, OutData, OutValid, OutLast
    );

    modport slave (
        output FIFOEmpty, RDData, BurstLen, OutReady,
        input  FIFORdReq, OutData, OutValid, OutLast
    );
endinterface

// File: rtl/stream_buf2.sv
// Small register FIFO; head entry is always slot 0 so head_data is a plain register.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    logic [Width-1:0] mem_reg   [OUT_BUF_DEPTH];
    logic [Width-1:0] shift_src [OUT_BUF_DEPTH];
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;

    assign pop_ok     = pop && (count_reg != '0);
    // On a simultaneous pop the tail moves down one slot, so the push lands one lower.
    assign wr_idx     = pop_ok ? count_reg - CNT_W'(1) : count_reg;
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop_ok);

    for (genvar gi = 0; gi < OUT_BUF_DEPTH; gi++) begin : g_shift
        if (gi < OUT_BUF_DEPTH - 1) begin : g_mid
            assign shift_src[gi] = mem_reg[gi+1];
        end else begin : g_top
            assign shift_src[gi] = mem_reg[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            for (int i = 0; i < OUT_BUF_DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                if (push && (wr_idx == CNT_W'(i))) mem_reg[i] <= push_data;
                else if (pop_ok)                   mem_reg[i] <= shift_src[i];
            end
        end
    end

    assign head_data = mem_reg[0];
    assign count     = count_reg;
endmodule

// File: rtl/sfifo_stream_reader.sv
// Converts a one-cycle-latency FIFO read port into a full-throughput valid/ready
// stream with an optional burst framer driving OutLast.
module sfifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int Width    = 8,
    parameter int LenWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sfifo_stream_reader_if.master bus
);
    localparam int SW = CNT_W + 1;

    logic [CNT_W-1:0]    occ;
    logic                inflight_reg;
    logic [LenWidth-1:0] beat_reg;
    logic [LenWidth-1:0] cur_len_reg;
    logic [LenWidth-1:0] len;
    logic [SW-1:0]       space;
    logic                transfer;
    logic                last;

    stream_buf2 #(.Width(Width)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (bus.RDData),
        .pop       (transfer),
        .head_data (bus.OutData),
        .count     (occ)
    );

    assign bus.OutValid = (occ != '0);
    assign transfer     = bus.OutValid && bus.OutReady;

    // Credits: free slots minus the word already on its way, plus the slot freed this edge.
    assign space = SW'(OUT_BUF_DEPTH) - SW'(occ) - SW'(inflight_reg) + SW'(transfer);
    assign bus.FIFORdReq = !reset && !bus.FIFOEmpty && (space != '0);

    // The first word of a burst must see the live length since cur_len is not loaded yet.
    assign len  = (beat_reg == '0) ? bus.BurstLen : cur_len_reg;
    assign last = bus.OutValid && (len != '0) && (beat_reg == len - LenWidth'(1));
    assign bus.OutLast = last;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_reg <= 1'b0;
            beat_reg     <= '0;
            cur_len_reg  <= '0;
        end else begin
            inflight_reg <= bus.FIFORdReq;
            if (transfer) begin
                if (beat_reg == '0) cur_len_reg <= bus.BurstLen;
                beat_reg <= last ? '0 : beat_reg + LenWidth'(1);
            end
            assert (int'(occ) + int'(inflight_reg) <= OUT_BUF_DEPTH);
        end
    end
endmodule
